// File: rtl/multiphase_clkgen.sv
// Counter-based multiphase clock generator: NUM_PHASES non-overlapping strobes
// from one master clock, each slot being GAP_W dead cycles then PULSE_W high cycles.

module multiphase_clkgen_strobe (
  input  logic master,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  input  logic val,
  output logic phi
);
  always_ff @(posedge master) begin
    if (!rst_n)    phi <= 1'b0;
    else if (clr)  phi <= 1'b0;
    else if (load) phi <= val;
  end
endmodule

module multiphase_clkgen #(
  parameter int NUM_PHASES = 4,
  parameter int PULSE_W    = 4,
  parameter int GAP_W      = 1,
  parameter int IDX_W      = $clog2(NUM_PHASES)
) (
  input  logic                  master,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_PHASES-1:0] phase_mask,
  output logic [NUM_PHASES-1:0] phi,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  cycle_start,
  output logic                  active
);
  localparam int MAXC = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GAP = 2'd1, PULSE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [NUM_PHASES-1:0] ld, clr, val;
  logic cs_d, act_d;

  // state register
  always_ff @(posedge master) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (en) state_d = GAP;
      end
      GAP: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == CW'(GAP_W - 1)) begin
          state_d = PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PULSE: begin
        // en is only looked at once the pulse has run its full width
        if (cnt_q == CW'(PULSE_W - 1)) begin
          cnt_d = '0;
          if (en) begin
            state_d = GAP;
            idx_d   = (idx_q == IDX_W'(NUM_PHASES - 1)) ? '0 : idx_q + IDX_W'(1);
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // output decode; mask is captured only on entry to PULSE
  always_comb begin
    cs_d  = (state_d == GAP) && (state_q != GAP) && (idx_d == '0);
    act_d = (state_d != IDLE);
    for (int k = 0; k < NUM_PHASES; k++) begin
      ld[k]  = (state_q != PULSE) && (state_d == PULSE);
      clr[k] = (state_d != PULSE);
      val[k] = (idx_d == IDX_W'(k)) && !phase_mask[k];
    end
  end

  always_ff @(posedge master) begin
    if (!rst_n) begin
      cycle_start <= 1'b0;
      active      <= 1'b0;
    end else begin
      cycle_start <= cs_d;
      active      <= act_d;
    end
  end

  assign phase_idx = idx_q;

  for (genvar k = 0; k < NUM_PHASES; k++) begin : g_ph
    multiphase_clkgen_strobe u_strb (
      .master (master),
      .rst_n  (rst_n),
      .load   (ld[k]),
      .clr    (clr[k]),
      .val    (val[k]),
      .phi    (phi[k])
    );
  end
endmodule

// File: tb/tb_multiphase_clkgen.sv
// Directed bench: default 4-phase instance plus a 2-phase W=1/G=1 instance.
module tb_multiphase_clkgen;
  logic master = 1'b0;
  logic rst_n, en;
  logic [3:0] mask;
  logic [3:0] phi;
  logic [1:0] idx;
  logic cs, act;
  logic [1:0] phi2;
  logic       idx2;
  logic cs2, act2;

  int vec = 0;
  int bad = 0;
  int viol = 0;

  always #5 master = ~master;

  multiphase_clkgen dut (
    .master(master), .rst_n(rst_n), .en(en), .phase_mask(mask),
    .phi(phi), .phase_idx(idx), .cycle_start(cs), .active(act)
  );

  multiphase_clkgen #(.NUM_PHASES(2), .PULSE_W(1), .GAP_W(1)) dut2 (
    .master(master), .rst_n(rst_n), .en(en), .phase_mask(2'b00),
    .phi(phi2), .phase_idx(idx2), .cycle_start(cs2), .active(act2)
  );

  always @(negedge master) begin
    assert ($countones(phi) <= 1 && $countones(phi2) <= 1)
      else $display("popcount violation phi=%b phi2=%b", phi, phi2);
    if ($countones(phi) > 1 || $countones(phi2) > 1) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge master);
    #1;
  endtask

  // returns with the bench sitting in the first GAP cycle (t0)
  task automatic start();
    rst_n = 1'b0; en = 1'b0;
    tick();
    rst_n = 1'b1; en = 1'b1;
    tick();
  endtask

  // {cycle_start, active, phase_idx, phi} for default instance, k cycles after t0
  function automatic logic [7:0] exp1(input int k, input logic [3:0] m);
    int pos, slot, off;
    logic [3:0] p;
    logic [31:0] s;
    pos  = k % 20;
    slot = pos / 5;
    off  = pos % 5;
    s    = slot;
    p    = (off >= 1) ? (4'b0001 << slot) : 4'b0000;
    p    = p & ~m;
    return {(pos == 0), 1'b1, s[1:0], p};
  endfunction

  function automatic logic [4:0] exp2(input int k);
    int pos, slot, off;
    logic [1:0] p;
    logic [31:0] s;
    pos  = k % 4;
    slot = pos / 2;
    off  = pos % 2;
    s    = slot;
    p    = (off == 1) ? (2'b01 << slot) : 2'b00;
    return {(pos == 0), 1'b1, s[0], p};
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; mask = 4'b0000;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset", {cs, act, idx, phi}, 8'h00);
      chk("reset2", {cs2, act2, idx2, phi2}, 5'h00);
    end

    // free-run, both instances
    start();
    for (int k = 0; k <= 41; k++) begin
      chk($sformatf("free k=%0d", k), {cs, act, idx, phi}, exp1(k, 4'b0000));
      chk($sformatf("sweep k=%0d", k), {cs2, act2, idx2, phi2}, exp2(k));
      tick();
    end

    // en drops in 2nd cycle of phi[1]; pulse completes, then idle
    start();
    for (int k = 0; k <= 14; k++) begin
      chk($sformatf("stop_pulse k=%0d", k), {cs, act, idx, phi},
          (k <= 9) ? exp1(k, 4'b0000) : 8'h00);
      if (k == 7) en = 1'b0;
      tick();
    end

    // en drops in gap before phi[2]
    start();
    for (int k = 0; k <= 16; k++) begin
      chk($sformatf("stop_gap k=%0d", k), {cs, act, idx, phi},
          (k <= 10) ? exp1(k, 4'b0000) : 8'h00);
      if (k == 10) en = 1'b0;
      tick();
    end

    // phi[1] masked; slot still consumed
    mask = 4'b0010;
    start();
    for (int k = 0; k <= 21; k++) begin
      chk($sformatf("mask k=%0d", k), {cs, act, idx, phi}, exp1(k, 4'b0010));
      tick();
    end
    mask = 4'b0000;

    // reset while phi[2] is high, then restart
    start();
    for (int k = 0; k <= 22; k++) begin
      chk($sformatf("rst_mid k=%0d", k), {cs, act, idx, phi},
          (k <= 12) ? exp1(k, 4'b0000) : (k == 13) ? 8'h00 : exp1(k - 14, 4'b0000));
      if (k == 12) rst_n = 1'b0;
      if (k == 13) rst_n = 1'b1;
      tick();
    end

    chk("onehot", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/multiphase_clkgen.md
Name: multiphase_clkgen

Overview:
- Synthesisable, parametrised successor to the two-phase clock generator.
- Derives NUM_PHASES non-overlapping phase strobes from the single master clock using counters, not delays.
- Pulse width and dead time are in master cycles, with a start/stop control and a per-phase mask.
- Drives the phase-enable inputs of the pipelined datapath stages; one phase per stage by default.

Parameters:
- NUM_PHASES, 4, number of phase outputs; legal range 2..16.
- PULSE_W, 4, master cycles each phase strobe is high; must be ≥1.
- GAP_W, 1, dead-time master cycles with all strobes low before each pulse; must be ≥1, guaranteeing non-overlap.
- IDX_W, $clog2(NUM_PHASES), width of the phase index output.

Ports:
- master  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of master.
- en  input  1  run request; 1 = generate phases, 0 = stop at the next phase boundary.
- phase_mask  input  NUM_PHASES  bit k=1 suppresses phi[k]; its time slot is still consumed.
- phi  output  NUM_PHASES  registered phase strobes; at most one bit high in any cycle.
- phase_idx  output  IDX_W  index of the phase whose slot (gap+pulse) is current.
- cycle_start  output  1  one-cycle pulse in the first gap cycle of phase 0.
- active  output  1  high whenever state ≠ IDLE.

Behaviour:
- All outputs are registered. rst_n=0 at an edge forces:
  - state=IDLE, phi=0, phase_idx=0, cycle_start=0, active=0, internal counter=0.
  - This takes effect on that edge, including mid-pulse; a truncated pulse is acceptable.
- States:
  - IDLE: all outputs low.
  - GAP: phi=0, lasts GAP_W cycles.
  - PULSE: phi[phase_idx]=~phase_mask[phase_idx], lasts PULSE_W cycles.
- IDLE→GAP: on an edge with en=1.
  - Next cycle: phase_idx=0, active=1, cycle_start=1.
- GAP→PULSE: after GAP_W cycles in GAP.
  - First strobe goes high GAP_W cycles after the edge that left IDLE.
- PULSE→GAP (next phase): after PULSE_W cycles, if en=1.
  - phase_idx increments and wraps NUM_PHASES-1 → 0.
  - cycle_start=1 on the first GAP cycle whenever the new idx is 0.
- PULSE→IDLE: after PULSE_W cycles, if en=0.
  - A started pulse is always completed at full width.
- GAP→IDLE: if en=0 is sampled at any GAP cycle, go IDLE on that edge. No strobe is emitted.
- Period: NUM_PHASES*(GAP_W+PULSE_W) master cycles; no extra cycles at wrap.
- phase_mask is sampled on the first PULSE cycle and held for the whole pulse. A mid-pulse change has no effect until the next pulse.
- Invariant: popcount(phi) ≤ 1 every cycle, and ≥GAP_W all-low cycles lie between any two strobes.
- en toggling inside PULSE is ignored until the pulse end.
- Counter width: $clog2(max(PULSE_W,GAP_W)+1) bits; it never overflows.

Test Plan:
- Reset/idle (defaults N=4, W=4, G=1): rst_n=0 for 3 cycles, en=0 → phi=0000, phase_idx=0, active=0, cycle_start=0 throughout.
- Free-run: en=1 held from edge t0 →
  - phi[0] high t0+1..t0+4, phi[1] high t0+6..t0+9, phi[2] t0+11..t0+14, phi[3] t0+16..t0+19, phi[0] again from t0+21.
  - cycle_start high at t0 and t0+20; period 20.
- Stop mid-pulse: drop en at the 2nd cycle of phi[1] → phi[1] stays high its full 4 cycles, then IDLE. active=0 next cycle; no phi[2].
- Stop in gap: en=0 sampled during the gap before phi[2] → IDLE on that edge, phi stays 0000.
- Mask: phase_mask=0010 with free-run → phi[1] never rises; phi[2] still starts exactly 10 cycles after phi[0]'s rise. phase_idx still steps 0,1,2,3.
- Reset mid-pulse: rst_n=0 during phi[2] high → next edge phi=0000, IDLE. With en=1 and rst_n released, the sequence restarts with phase 0 and cycle_start=1.
- Every scenario: assertion that popcount(phi) ≤ 1; parameter sweep N=2, W=1, G=1 gives period 4.
